seg7_scan_driver: RTL and testbench

- Consumes the six BCD digits and alarm flag produced by the clock/alarm/stopwatch mode mux.
- Drives a 6-digit time-multiplexed common-anode 7-segment display.
- Snapshots the inputs once per frame so digits do not tear, decodes BCD, inserts a one-cycle anti-ghost blank between digits, and can blink the whole display on alarm.
- Sits between the mode mux and the board display pins.

---
 rtl/seg7_scan_driver.sv | 174 +++++++++++++++++
 tb/tb_seg7_scan_driver.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/seg7_scan_driver.sv
`default_nettype none
// ============================================================================
// Module      : seg7_scan_driver
// Description : Drives a six-digit, time-multiplexed, common-anode 7-segment
//               display from six BCD digits.
//               - The inputs are captured once per frame, so a digit never
//                 changes partway through a scan.
//               - Each digit is decoded from BCD to segments.
//               - All anodes are blanked for one cycle between digits, which
//                 stops the previous digit ghosting onto the next one.
//               Optional macro BLINK_EN: when defined, the alarm input blinks
//               the whole display. When it is undefined, alarm is ignored and
//               no blink logic is built.
// Revision    : 1.0 - initial release
// ============================================================================
module seg7_scan_driver #(
    parameter int SCAN_DIV  = 50000,     // clk cycles per digit slot (>= 2)
    parameter int BLINK_DIV = 12500000   // clk cycles per blink half-period (>= 2)
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] d0,
    input  logic [3:0] d1,
    input  logic [3:0] d2,
    input  logic [3:0] d3,
    input  logic [3:0] d4,
    input  logic [3:0] d5,
    input  logic [5:0] dp_mask,
    input  logic       alarm,
    output logic [5:0] an,
    output logic [6:0] seg,
    output logic       dp,
    output logic       frame_done
);

    localparam int            c_CNT_W   = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_MAX = c_CNT_W'(SCAN_DIV - 1);
    localparam logic [2:0]    c_IDX_LAST = 3'd5;
    localparam logic [5:0]    c_AN_OFF   = 6'b111111;
    localparam logic [6:0]    c_SEG_OFF  = 7'h7F;

    // Segment pattern for one BCD digit, active-low, bit order g..a.
    // Codes 10..15 are not valid BCD and are shown as a single dash.
    function automatic logic [6:0] f_decode(input logic [3:0] bcd);
        logic [6:0] v;
        case (bcd)
            4'd0:    v = 7'b1000000;
            4'd1:    v = 7'b1111001;
            4'd2:    v = 7'b0100100;
            4'd3:    v = 7'b0110000;
            4'd4:    v = 7'b0011001;
            4'd5:    v = 7'b0010010;
            4'd6:    v = 7'b0000010;
            4'd7:    v = 7'b1111000;
            4'd8:    v = 7'b0000000;
            4'd9:    v = 7'b0010000;
            default: v = 7'b0111111;
        endcase
        return v;
    endfunction

    logic [c_CNT_W-1:0] r_cnt;
    logic [2:0]         r_idx;
    logic [3:0]         r_shadow [0:5];
    logic [5:0]         r_shadow_dp;
    logic [5:0]         r_an;
    logic [6:0]         r_seg;
    logic               r_dp;
    logic               r_frame_done;

    logic               w_tick;
    logic               w_slot_start;
    logic [5:0]         w_an_d;
    logic               w_blank_all;

    assign w_tick       = (r_cnt == c_CNT_MAX);
    assign w_slot_start = (r_cnt == '0);

`ifdef BLINK_EN
    localparam int c_BLK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [c_BLK_W-1:0] c_BLK_MAX = c_BLK_W'(BLINK_DIV - 1);

    logic [c_BLK_W-1:0] r_blink_cnt;
    logic               r_phase;

    // Blink timer: it runs only while alarm is held, and the phase toggles
    // every BLINK_DIV cycles. Phase starts at 0, so the display stays lit for
    // the first half-period after alarm rises.
    always_ff @(posedge clk) begin
        if (rst || !alarm) begin
            r_blink_cnt <= '0;
            r_phase     <= 1'b0;
        end else if (r_blink_cnt == c_BLK_MAX) begin
            r_blink_cnt <= '0;
            r_phase     <= ~r_phase;
        end else begin
            r_blink_cnt <= r_blink_cnt + 1'b1;
        end
    end

    assign w_blank_all = r_phase;
`else
    logic w_unused_blink;

    // alarm has no effect in this build. This term only keeps the port and
    // parameter formally referenced.
    assign w_unused_blink = alarm ^ (BLINK_DIV == 0);
    assign w_blank_all    = 1'b0;
`endif

    // Next anode pattern:
    // - blank on the slot boundary;
    // - select the current digit at the start of its slot;
    // - otherwise hold.
    // A blink blank overrides all of these. Scanning itself carries on
    // underneath the blink.
    always_comb begin
        w_an_d = r_an;
        if (w_tick) begin
            w_an_d = c_AN_OFF;
        end else if (w_slot_start) begin
            w_an_d = ~(6'd1 << r_idx);
        end
        if (w_blank_all) begin
            w_an_d = c_AN_OFF;
        end
    end

    // Scan engine. It advances the prescaler and the digit index, updates the
    // registered display outputs, and takes the per-frame snapshot after the
    // last digit's slot.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt        <= '0;
            r_idx        <= '0;
            r_shadow     <= '{default: 4'd0};
            r_shadow_dp  <= '0;
            r_an         <= c_AN_OFF;
            r_seg        <= c_SEG_OFF;
            r_dp         <= 1'b1;
            r_frame_done <= 1'b0;
        end else begin
            r_an         <= w_an_d;
            r_frame_done <= 1'b0;
            if (w_tick) begin
                r_cnt <= '0;
                r_idx <= (r_idx == c_IDX_LAST) ? 3'd0 : r_idx + 3'd1;
                if (r_idx == c_IDX_LAST) begin
                    r_shadow[0]  <= d0;
                    r_shadow[1]  <= d1;
                    r_shadow[2]  <= d2;
                    r_shadow[3]  <= d3;
                    r_shadow[4]  <= d4;
                    r_shadow[5]  <= d5;
                    r_shadow_dp  <= dp_mask;
                    r_frame_done <= 1'b1;
                end
            end else begin
                r_cnt <= r_cnt + 1'b1;
                if (w_slot_start) begin
                    r_seg <= f_decode(r_shadow[r_idx]);
                    r_dp  <= ~r_shadow_dp[r_idx];
                end
            end
        end
    end

    assign an         = r_an;
    assign seg        = r_seg;
    assign dp         = r_dp;
    assign frame_done = r_frame_done;

endmodule
`default_nettype wire

// File: tb/tb_seg7_scan_driver.sv
`default_nettype none
// ============================================================================
// Module      : tb_seg7_scan_driver
// Description : Scoreboard bench for seg7_scan_driver (SCAN_DIV=4,
//               BLINK_DIV=16). The stimulus queues the hand-computed pattern
//               expected for each digit slot. A monitor pops one entry each
//               time a digit lights and compares it with the outputs. The
//               monitor also checks the lit length of every slot and the
//               position of frame_done.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seg7_scan_driver;

    localparam int c_SCAN  = 4;
    localparam int c_BLINK = 16;

    typedef struct packed {
        logic [5:0] an;
        logic [6:0] seg;
        logic       dp;
    } slot_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] d0 = '0, d1 = '0, d2 = '0, d3 = '0, d4 = '0, d5 = '0;
    logic [5:0] dp_mask = '0;
    logic       alarm = 1'b0;
    logic [5:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       frame_done;

    int    checks = 0;
    int    errors = 0;
    bit    mon_en = 1'b1;
    slot_t exp_q [$];

    // Expected segment sets, packed {slot5, ..., slot0}
    localparam logic [41:0] c_ZEROS  = {6{7'h40}};
    localparam logic [41:0] c_FRAME1 = {7'h24, 7'h30, 7'h12, 7'h10, 7'h40, 7'h78};
    localparam logic [41:0] c_FRAME2 = {7'h24, 7'h30, 7'h3F, 7'h10, 7'h40, 7'h19};

    seg7_scan_driver #(
        .SCAN_DIV  (c_SCAN),
        .BLINK_DIV (c_BLINK)
    ) u_dut (
        .clk        (clk),
        .rst        (rst),
        .d0         (d0),
        .d1         (d1),
        .d2         (d2),
        .d3         (d3),
        .d4         (d4),
        .d5         (d5),
        .dp_mask    (dp_mask),
        .alarm      (alarm),
        .an         (an),
        .seg        (seg),
        .dp         (dp),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic push_frame(input logic [41:0] segs, input logic [5:0] dpn, input int nslots);
        slot_t s;
        for (int i = 0; i < nslots; i++) begin
            s.an  = ~(6'd1 << i);
            s.seg = segs[i*7 +: 7];
            s.dp  = dpn[i];
            exp_q.push_back(s);
        end
    endtask

    task automatic wait_fd(input string name);
        bit seen;
        seen = 1'b0;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            if (frame_done) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) chk(name, 32'd0, 32'd1);
    endtask

    // Monitor: it compares each newly lit digit with the head of the queue,
    // checks the lit length of every slot, and checks where frame_done falls.
    initial begin
        logic [5:0] prev_an;
        logic [5:0] last_lit;
        logic       prev_fd;
        int         run;
        slot_t      e;
        prev_an  = 6'h3F;
        last_lit = 6'h3F;
        prev_fd  = 1'b0;
        run      = 0;
        forever begin
            @(negedge clk);
            if (rst || !mon_en) begin
                prev_an  = 6'h3F;
                last_lit = 6'h3F;
                prev_fd  = 1'b0;
                run      = 0;
            end else begin
                if (an != 6'h3F && prev_an == 6'h3F) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_slot", {26'd0, an}, 32'h3F);
                    end else begin
                        e = exp_q.pop_front();
                        chk("slot", {18'd0, an, seg, dp}, {18'd0, e});
                    end
                end
                if (an != 6'h3F) begin
                    run++;
                    last_lit = an;
                end else if (prev_an != 6'h3F) begin
                    chk("slot_len", run, c_SCAN - 1);
                    run = 0;
                end
                if (frame_done) begin
                    chk("fd_pos", {20'd0, last_lit, an}, {20'd0, 6'b011111, 6'h3F});
                    chk("fd_pulse", {31'd0, prev_fd}, 32'd0);
                end
                prev_an = an;
                prev_fd = frame_done;
            end
        end
    end

    initial begin
        int lit_early;
        int lit_late;
        bit seen;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_an", {26'd0, an}, 32'h3F);
        chk("rst_seg", {25'd0, seg}, 32'h7F);
        chk("rst_dp", {31'd0, dp}, 32'd1);
        chk("rst_fd", {31'd0, frame_done}, 32'd0);

        // First frame shows zeros. New inputs are captured at the end of it.
        push_frame(c_ZEROS, 6'h3F, 6);
        {d5, d4, d3, d2, d1, d0} = {4'd2, 4'd3, 4'd5, 4'd9, 4'd0, 4'd7};
        dp_mask = 6'b010100;
        #1 rst = 1'b0;

        wait_fd("timeout_fd0");
        push_frame(c_FRAME1, 6'b101011, 6);
        // These changes land mid-frame and must stay invisible until the next snapshot.
        d0 = 4'd4;
        d3 = 4'hC;

        wait_fd("timeout_fd1");
        push_frame(c_FRAME2, 6'b101011, 6);

        wait_fd("timeout_fd2");
        push_frame(c_FRAME2, 6'b101011, 4);

        // Reset while slot 3 is lit
        seen = 1'b0;
        for (int n = 0; n < 100; n++) begin
            @(negedge clk);
            if (an == 6'b110111) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) chk("timeout_slot3", 32'd0, 32'd1);
        #1 rst = 1'b1;
        @(negedge clk);
        chk("midrst_an", {26'd0, an}, 32'h3F);
        chk("midrst_seg", {25'd0, seg}, 32'h7F);
        chk("midrst_dp", {31'd0, dp}, 32'd1);
        chk("midrst_fd", {31'd0, frame_done}, 32'd0);
        push_frame(c_ZEROS, 6'h3F, 6);
        #1 rst = 1'b0;

        wait_fd("timeout_fd3");
        push_frame(c_FRAME2, 6'b101011, 6);
        wait_fd("timeout_fd4");
        #1 mon_en = 1'b0;
        chk("queue_empty", exp_q.size(), 32'd0);

        // Alarm / blink behaviour
        @(negedge clk);
        alarm     = 1'b1;
        lit_early = 0;
        lit_late  = 0;
        for (int k = 1; k <= 32; k++) begin
            @(negedge clk);
            if (k <= 15 && an != 6'h3F) lit_early++;
            if (k >= 18 && k <= 31 && an != 6'h3F) lit_late++;
        end
        chk("alarm_early_lit", {31'd0, (lit_early > 0)}, 32'd1);
`ifdef BLINK_EN
        chk("blink_dark", lit_late, 32'd0);
`else
        chk("no_blink_lit", {31'd0, (lit_late > 0)}, 32'd1);
`endif
        alarm = 1'b0;
        seen  = 1'b0;
        for (int n = 0; n < 3 * c_SCAN; n++) begin
            @(negedge clk);
            if (an != 6'h3F) begin
                seen = 1'b1;
                break;
            end
        end
        chk("alarm_resume", {31'd0, seen}, 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
